divide_fix_32_8: RTL and testbench
==================================

# divide_fix_32_8

Fully pipelined unsigned fixed-point divider: a 32-bit dividend by an 8-bit divisor, giving a 32-bit integer quotient. It wraps a restoring-division datapath behind AXI-Stream-style valid-only ports, so it can replace a vendor divider core in the datapath. It accepts one operand pair per clock, with a fixed latency and no backpressure.

## Interface
Parameters:
- DATAWIDTH_IN, 32, dividend width (tdata of port a)
- DATAWIDTH_OUT, 32, quotient width; must equal DATAWIDTH_IN
- DIVISOR_WIDTH, 8, divisor width (tdata of port b)
- BITS_PER_STAGE, 8, quotient bits resolved per pipeline stage; DATAWIDTH_IN must be a multiple of it

Ports (one clock; reset is synchronous and active-high):
- aclk  in  1  clock, rising edge
- areset  in  1  synchronous active-high reset
- s_axis_a_tvalid  in  1  dividend valid
- s_axis_a_tdata  in  32  dividend, unsigned
- s_axis_b_tvalid  in  1  divisor valid
- s_axis_b_tdata  in  8  divisor, unsigned
- m_axis_result_tvalid  out  1  quotient valid, one-cycle pulse per result
- m_axis_result_tdata  out  32  quotient, unsigned

## Operation
- Result is floor(a / b), unsigned integer. No fractional bits are produced and the remainder is discarded.
- Issue: a pair is accepted on a rising edge when s_axis_a_tvalid and s_axis_b_tvalid are both 1.
- A lone valid (only a or only b high) is dropped. Nothing is buffered, and no result is generated for it.
- No tready on any port. The block always accepts, and the downstream must always accept.
- Divide by zero (b = 0x00): result is 0xFFFFFFFF, with tvalid asserted at normal latency.
- Division method: restoring long division, MSB first.
  - Each stage holds a partial remainder of DIVISOR_WIDTH+1 bits, the remaining dividend bits, the divisor, and the accumulated quotient bits.
  - Each stage performs BITS_PER_STAGE shift/compare/subtract steps.
- Quotient always fits in 32 bits, since b ≥ 1. No saturation is needed except for the zero-divisor case.
- A valid bit travels alongside each pipeline slot. Data registers in invalid slots may hold stale values.
- m_axis_result_tdata updates only when m_axis_result_tvalid is 1 and holds its last value otherwise.

## Timing
- Latency: DATAWIDTH_IN/BITS_PER_STAGE = 4 cycles.
  - A pair accepted at edge N produces m_axis_result_tvalid = 1 after edge N+4, for exactly one cycle.
- Throughput: one result per cycle. Back-to-back pairs emerge back-to-back, in order.
- Reset (areset = 1 at an edge):
  - All pipeline valid bits are cleared, so m_axis_result_tvalid = 0 and m_axis_result_tdata = 0.
  - Operations in flight are discarded and produce no output.
  - Inputs presented during reset are ignored.
- First acceptance is possible on the first edge with areset = 0.
- No state machine: a pure pipeline.

## Structure
- Shared package divide_fix_pkg holds:
  - DATAWIDTH_IN, DIVISOR_WIDTH, BITS_PER_STAGE
  - NUM_STAGES = DATAWIDTH_IN/BITS_PER_STAGE
  - DIV0_RESULT = all-ones constant
  - the stage-slot struct typedef (valid, remainder, dividend remainder bits, divisor, quotient).
- One sub-module, div_stage: a registered stage doing BITS_PER_STAGE restoring iterations. The top generates NUM_STAGES instances and performs the zero-divisor override at the output.

## Test plan
- Single op: a = 0x10000000, b = 0x80 on one edge → one tvalid pulse 4 cycles later with tdata = 0x00200000.
- Sweep: a = 0xFFFFFFFF with b = 0x01 → 0xFFFFFFFF; b = 0xFF → 0x01010101; b = 0x03 → 0x55555555.
- Zero divisor: a = 0x12345678, b = 0x00 → 0xFFFFFFFF after 4 cycles.
- Back-to-back issue: 8 consecutive random pairs → 8 consecutive valid results, in order, matching the reference model (a/b).
- Mismatched valids: a_tvalid = 1 with b_tvalid = 0, then the reverse → no output pulse ever.
- Reset mid-flight: issue 3 pairs, assert areset on the next edge → tvalid stays 0 and tdata = 0. A pair issued after reset completes normally.

Source files
------------

// File: rtl/divide_fix_pkg.sv
// rtl/divide_fix_pkg.sv - shared constants and pipeline slot type for the fixed-point divider
// Purpose: widths, stage count, zero-divisor result and the per-stage slot struct.
// Ports: none (package).
package divide_fix_pkg;

    localparam int DATAWIDTH_IN   = 32;
    localparam int DIVISOR_WIDTH  = 8;
    localparam int BITS_PER_STAGE = 8;
    localparam int NUM_STAGES     = DATAWIDTH_IN / BITS_PER_STAGE;

    localparam logic [DATAWIDTH_IN-1:0] DIV0_RESULT = '1;

    // One pipeline slot. The remainder is one bit wider than the divisor so the
    // shifted-in partial remainder can exceed the divisor before the subtract.
    typedef struct packed {
        logic                     valid;
        logic [DIVISOR_WIDTH:0]   rem;
        logic [DATAWIDTH_IN-1:0]  dvd;
        logic [DIVISOR_WIDTH-1:0] dsr;
        logic [DATAWIDTH_IN-1:0]  quo;
    } slot_t;

endpackage

// File: rtl/div_stage.sv
// rtl/div_stage.sv - one registered restoring-division stage
// Purpose: resolves BITS_PER_STAGE quotient bits, MSB first, then registers the slot.
// Ports:
//   i_clk   clock, rising edge
//   i_rst   synchronous active-high reset, clears the slot valid bit
//   i_slot  incoming slot (combinational from previous stage register or inputs)
//   o_slot  registered outgoing slot
module div_stage
    import divide_fix_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  slot_t i_slot,
    output slot_t o_slot
);

    slot_t                  w_next;
    logic [DIVISOR_WIDTH:0] w_shift;
    slot_t                  r_slot;

    always_comb begin
        w_next  = i_slot;
        w_shift = '0;
        for (int k = 0; k < BITS_PER_STAGE; k++) begin
            // Bring down the next dividend bit into the partial remainder.
            w_shift    = {w_next.rem[DIVISOR_WIDTH-1:0], w_next.dvd[DATAWIDTH_IN-1]};
            w_next.dvd = {w_next.dvd[DATAWIDTH_IN-2:0], 1'b0};
            if (w_shift >= {1'b0, w_next.dsr}) begin
                w_next.rem = w_shift - {1'b0, w_next.dsr};
                w_next.quo = {w_next.quo[DATAWIDTH_IN-2:0], 1'b1};
            end else begin
                w_next.rem = w_shift;
                w_next.quo = {w_next.quo[DATAWIDTH_IN-2:0], 1'b0};
            end
        end
    end

    // Data always loads; only the valid bit needs a reset value.
    always_ff @(posedge i_clk) begin
        r_slot <= w_next;
        if (i_rst) begin
            r_slot.valid <= 1'b0;
        end
    end

    assign o_slot = r_slot;

endmodule

// File: rtl/divide_fix_32_8.sv
// rtl/divide_fix_32_8.sv - pipelined 32-bit by 8-bit unsigned divider, valid-only streams
// Purpose: floor(a / b) with fixed latency NUM_STAGES, one pair per clock, no backpressure.
//   A divisor of zero yields all ones.
// Ports:
//   aclk                  clock, rising edge
//   areset                synchronous active-high reset
//   s_axis_a_tvalid/tdata dividend stream (32 bits)
//   s_axis_b_tvalid/tdata divisor stream (8 bits)
//   m_axis_result_tvalid  one-cycle pulse per quotient
//   m_axis_result_tdata   quotient, held between pulses
module divide_fix_32_8 #(
    parameter int DATAWIDTH_IN   = divide_fix_pkg::DATAWIDTH_IN,
    parameter int DATAWIDTH_OUT  = divide_fix_pkg::DATAWIDTH_IN,
    parameter int DIVISOR_WIDTH  = divide_fix_pkg::DIVISOR_WIDTH,
    parameter int BITS_PER_STAGE = divide_fix_pkg::BITS_PER_STAGE
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     s_axis_a_tvalid,
    input  logic [DATAWIDTH_IN-1:0]  s_axis_a_tdata,
    input  logic                     s_axis_b_tvalid,
    input  logic [DIVISOR_WIDTH-1:0] s_axis_b_tdata,
    output logic                     m_axis_result_tvalid,
    output logic [DATAWIDTH_OUT-1:0] m_axis_result_tdata
);

    localparam int NSTG = DATAWIDTH_IN / BITS_PER_STAGE;

    divide_fix_pkg::slot_t w_chain [0:NSTG];
    divide_fix_pkg::slot_t w_last;
    logic                  w_unused;

    logic                     r_tvalid;
    logic [DATAWIDTH_OUT-1:0] r_tdata;

    // A lone valid on either port simply yields an invalid slot.
    always_comb begin
        w_chain[0]       = '0;
        w_chain[0].valid = s_axis_a_tvalid & s_axis_b_tvalid;
        w_chain[0].dvd   = s_axis_a_tdata;
        w_chain[0].dsr   = s_axis_b_tdata;
    end

    for (genvar g = 0; g < NSTG; g++) begin : g_stage
        div_stage u_stage (
            .i_clk  (aclk),
            .i_rst  (areset),
            .i_slot (w_chain[g]),
            .o_slot (w_chain[g+1])
        );
    end

    assign w_last = w_chain[NSTG];

    // Final remainder and exhausted dividend bits are not needed.
    assign w_unused = ^{w_last.rem, w_last.dvd};

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
        end else begin
            r_tvalid <= w_last.valid;
            if (w_last.valid) begin
                r_tdata <= (w_last.dsr == '0) ? divide_fix_pkg::DIV0_RESULT : w_last.quo;
            end
        end
    end

    assign m_axis_result_tvalid = r_tvalid;
    assign m_axis_result_tdata  = r_tdata;

endmodule

// File: tb/tb_divide_fix_32_8.sv
// tb/tb_divide_fix_32_8.sv - self-checking bench for divide_fix_32_8 with random and directed stimulus
module tb_divide_fix_32_8;

    logic        aclk;
    logic        areset;
    logic        a_tvalid;
    logic [31:0] a_tdata;
    logic        b_tvalid;
    logic [7:0]  b_tdata;
    logic        r_tvalid;
    logic [31:0] r_tdata;

    divide_fix_32_8 dut (
        .aclk                 (aclk),
        .areset               (areset),
        .s_axis_a_tvalid      (a_tvalid),
        .s_axis_a_tdata       (a_tdata),
        .s_axis_b_tvalid      (b_tvalid),
        .s_axis_b_tdata       (b_tdata),
        .m_axis_result_tvalid (r_tvalid),
        .m_axis_result_tdata  (r_tdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic        mon_en = 1'b0;
    logic        exp_v;
    logic [31:0] last_data = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, expv, cyc);
    endtask

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [7:0] b);
        if (b == 8'd0) return 32'hFFFF_FFFF;
        return a / {24'd0, b};
    endfunction

    // Driven at a negedge, accepted at the next posedge, visible one negedge
    // after the fourth following posedge.
    task automatic drive(input logic va, input logic vb, input logic [31:0] a, input logic [7:0] b);
        exp_t e;
        @(negedge aclk);
        a_tvalid = va;
        b_tvalid = vb;
        a_tdata  = a;
        b_tdata  = b;
        if (va && vb && !areset) begin
            e.due  = cyc + 5;
            e.data = ref_div(a, b);
            q.push_back(e);
        end
    endtask

    always @(posedge aclk) begin
        cyc++;
        if (areset) begin
            q.delete();
            last_data = 32'h0;
        end
    end

    always @(negedge aclk) begin
        if (mon_en) begin
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            chk("tvalid", {31'd0, r_tvalid}, {31'd0, exp_v});
            if (exp_v) begin
                chk("tdata", r_tdata, q[0].data);
                last_data = q[0].data;
                void'(q.pop_front());
            end else begin
                chk("hold", r_tdata, last_data);
                if ((q.size() > 0) && (q[0].due < cyc)) void'(q.pop_front());
            end
        end
    end

    initial begin
        areset   = 1'b1;
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        a_tdata  = 32'h0;
        b_tdata  = 8'h0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_tvalid", {31'd0, r_tvalid}, 32'd0);
        chk("reset_tdata", r_tdata, 32'd0);
        areset = 1'b0;
        mon_en = 1'b1;

        // Single op and sweep, with idle gaps.
        drive(1, 1, 32'h1000_0000, 8'h80);
        repeat (6) drive(0, 0, 32'h0, 8'h0);
        drive(1, 1, 32'hFFFF_FFFF, 8'h01);
        drive(0, 0, 32'h0, 8'h0);
        drive(1, 1, 32'hFFFF_FFFF, 8'hFF);
        drive(0, 0, 32'h0, 8'h0);
        drive(1, 1, 32'hFFFF_FFFF, 8'h03);
        repeat (6) drive(0, 0, 32'h0, 8'h0);

        // Zero divisor.
        drive(1, 1, 32'h1234_5678, 8'h00);
        repeat (6) drive(0, 0, 32'h0, 8'h0);

        // Back-to-back random pairs.
        for (int i = 0; i < 8; i++) drive(1, 1, $urandom, 8'($urandom));
        repeat (6) drive(0, 0, 32'h0, 8'h0);

        // Mismatched valids must never produce a pulse.
        drive(1, 0, 32'hDEAD_BEEF, 8'h11);
        drive(0, 1, 32'hCAFE_F00D, 8'h22);
        repeat (6) drive(0, 0, 32'h0, 8'h0);

        // Reset with three operations in flight; inputs during reset ignored.
        for (int i = 0; i < 3; i++) drive(1, 1, $urandom, 8'($urandom_range(1, 255)));
        @(negedge aclk);
        areset   = 1'b1;
        a_tvalid = 1'b1;
        b_tvalid = 1'b1;
        a_tdata  = 32'h5555_AAAA;
        b_tdata  = 8'h07;
        @(negedge aclk);
        areset   = 1'b0;
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        repeat (6) drive(0, 0, 32'h0, 8'h0);
        drive(1, 1, 32'h0000_00FF, 8'h10);
        repeat (6) drive(0, 0, 32'h0, 8'h0);

        // Random traffic with sparse valids, zero and small divisors.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] bv;
            case ($urandom_range(0, 3))
                0:       bv = 8'h00;
                1:       bv = 8'($urandom_range(1, 4));
                default: bv = 8'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom, bv);
        end
        repeat (8) drive(0, 0, 32'h0, 8'h0);

        chk("drain", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
